// File: rtl/seg7_pkg.sv
// Shared glyph constants, scan state encoding and leading-zero helper.
// Pure declarations, no logic of its own.
// Glyphs are active-high {g,f,e,d,c,b,a}; output polarity is applied by the top.
package seg7_pkg;

    localparam int MAX_DIGITS = 8;

    localparam logic [6:0] GLYPH_0    = 7'h3F;
    localparam logic [6:0] GLYPH_1    = 7'h06;
    localparam logic [6:0] GLYPH_2    = 7'h5B;
    localparam logic [6:0] GLYPH_3    = 7'h4F;
    localparam logic [6:0] GLYPH_4    = 7'h66;
    localparam logic [6:0] GLYPH_5    = 7'h6D;
    localparam logic [6:0] GLYPH_6    = 7'h7D;
    localparam logic [6:0] GLYPH_7    = 7'h07;
    localparam logic [6:0] GLYPH_8    = 7'h7F;
    localparam logic [6:0] GLYPH_9    = 7'h6F;
    localparam logic [6:0] GLYPH_A    = 7'h77;
    localparam logic [6:0] GLYPH_B    = 7'h7C;
    localparam logic [6:0] GLYPH_C    = 7'h39;
    localparam logic [6:0] GLYPH_D    = 7'h5E;
    localparam logic [6:0] GLYPH_E    = 7'h79;
    localparam logic [6:0] GLYPH_F    = 7'h71;
    localparam logic [6:0] GLYPH_DASH = 7'h40;

    typedef enum logic {
        SHOW  = 1'b0,
        BLANK = 1'b1
    } scan_state_t;

    // Bit i set when nibbles MAX_DIGITS-1..i are all zero; bit 0 is never set.
    // Callers with fewer digits zero-pad the upper nibbles.
    function automatic logic [MAX_DIGITS-1:0] lz_mask(input logic [4*MAX_DIGITS-1:0] nibbles);
        logic all_zero;
        lz_mask  = '0;
        all_zero = 1'b1;
        for (int i = MAX_DIGITS - 1; i >= 1; i--) begin
            all_zero   = all_zero & (nibbles[4*i +: 4] == 4'h0);
            lz_mask[i] = all_zero;
        end
    endfunction

endpackage

// File: rtl/seg7_glyph_decoder.sv
// Nibble to active-high 7-segment glyph, hex or decimal-with-dash mode.
// Latency: combinational.
// Backpressure: none.
module seg7_glyph_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       hex_mode,
    output logic [6:0] glyph
);

    // In decimal mode nibbles 10..15 are not numerals, so they render as a dash.
    always_comb begin
        glyph = GLYPH_DASH;
        case (nibble)
            4'h0: glyph = GLYPH_0;
            4'h1: glyph = GLYPH_1;
            4'h2: glyph = GLYPH_2;
            4'h3: glyph = GLYPH_3;
            4'h4: glyph = GLYPH_4;
            4'h5: glyph = GLYPH_5;
            4'h6: glyph = GLYPH_6;
            4'h7: glyph = GLYPH_7;
            4'h8: glyph = GLYPH_8;
            4'h9: glyph = GLYPH_9;
            4'hA: glyph = hex_mode ? GLYPH_A : GLYPH_DASH;
            4'hB: glyph = hex_mode ? GLYPH_B : GLYPH_DASH;
            4'hC: glyph = hex_mode ? GLYPH_C : GLYPH_DASH;
            4'hD: glyph = hex_mode ? GLYPH_D : GLYPH_DASH;
            4'hE: glyph = hex_mode ? GLYPH_E : GLYPH_DASH;
            4'hF: glyph = hex_mode ? GLYPH_F : GLYPH_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit 7-segment scanner with blank gap, LZ blanking and decimal points.
// Latency: 1 clock from index/shadow/mode change to seg/dp/digit_en.
// Backpressure: none; load captures unconditionally on every edge it is high.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 1000,
    parameter int BLANK_CYCLES   = 2,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] val,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    hex_mode,
    input  logic                    blank_lz,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    scan_tick
);

    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    // "Off" patterns double as XOR masks that apply output polarity.
    localparam logic [6:0]            SEG_OFF = {7{SEG_ACTIVE_LOW}};
    localparam logic                  DP_OFF  = SEG_ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] EN_OFF  = {NUM_DIGITS{DIG_ACTIVE_LOW}};

    scan_state_t             state;
    logic [PRE_W-1:0]        prescaler;
    logic [IDX_W-1:0]        index;
    logic [7:0]              blank_cnt;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic [NUM_DIGITS-1:0]   dp_shadow;

    logic [NUM_DIGITS-1:0]   en_sel;
    logic [3:0]              cur_nibble;
    logic                    cur_dp;
    logic [MAX_DIGITS-1:0]   lz_vec;
    logic                    lz_cur;
    logic [6:0]              glyph;
    logic [6:0]              glyph_lit;
    logic                    dp_lit;
    logic [NUM_DIGITS-1:0]   en_lit;
    logic                    term;
    logic                    last_idx;
    logic                    blank_done;

    seg7_glyph_decoder u_glyph (
        .nibble   (cur_nibble),
        .hex_mode (hex_mode),
        .glyph    (glyph)
    );

    // Select the active digit's nibble, dp request and leading-zero flag.
    always_comb begin
        en_sel     = '0;
        cur_nibble = 4'h0;
        cur_dp     = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (int'(index) == i) begin
                en_sel[i]  = 1'b1;
                cur_nibble = shadow[4*i +: 4];
                cur_dp     = dp_shadow[i];
            end
        end
        lz_vec = lz_mask((4*MAX_DIGITS)'(shadow));
        lz_cur = |(lz_vec & MAX_DIGITS'(en_sel));
    end

    // Active-high next output image; BLANK turns everything off.
    always_comb begin
        glyph_lit = 7'h00;
        dp_lit    = 1'b0;
        en_lit    = '0;
        if (state == SHOW) begin
            glyph_lit = (blank_lz && lz_cur) ? 7'h00 : glyph;
            dp_lit    = cur_dp;
            en_lit    = en_sel;
        end
    end

    assign term       = (prescaler == PRE_W'(SCAN_DIV - 1));
    assign last_idx   = (index == IDX_W'(NUM_DIGITS - 1));
    assign blank_done = (blank_cnt == 8'(BLANK_CYCLES - 1));

    // Scan FSM, prescaler, digit index and registered outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= SHOW;
            prescaler <= '0;
            index     <= '0;
            blank_cnt <= '0;
            seg       <= SEG_OFF;
            dp        <= DP_OFF;
            digit_en  <= EN_OFF;
            scan_tick <= 1'b0;
        end else begin
            seg       <= glyph_lit ^ SEG_OFF;
            dp        <= dp_lit ^ DP_OFF;
            digit_en  <= en_lit ^ EN_OFF;
            scan_tick <= 1'b0;
            case (state)
                SHOW: begin
                    if (term) begin
                        prescaler <= '0;
                        index     <= last_idx ? '0 : index + 1'b1;
                        scan_tick <= 1'b1;
                        if (BLANK_CYCLES != 0) begin
                            state     <= BLANK;
                            blank_cnt <= '0;
                        end
                    end else begin
                        prescaler <= prescaler + 1'b1;
                    end
                end
                BLANK: begin
                    if (blank_done) begin
                        state <= SHOW;
                    end else begin
                        blank_cnt <= blank_cnt + 1'b1;
                    end
                end
                default: state <= SHOW;
            endcase
        end
    end

    // Shadow registers; a held load simply recaptures every edge.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            shadow    <= '0;
            dp_shadow <= '0;
        end else if (load) begin
            shadow    <= val;
            dp_shadow <= dp_in;
        end
    end

endmodule
